weight_mem_ctrl: RTL and testbench
==================================

# weight_mem_ctrl

Sequencer for the 8x8 weight memory. It accepts a 64-entry weight stream from the host over a valid/ready handshake and issues the corresponding memory writes. On command, it issues SIZE column reads that feed the systolic array, and flags each returned column. It sits between the host/DMA weight port and the weight memory. It guarantees that write and read are never requested in the same cycle.

## Interface
- SIZE, 8, array dimension; the memory holds SIZE*SIZE 5-bit weights
- MEM_SIZE, SIZE*SIZE, total weight count
- WR_ADDR_W, $clog2(MEM_SIZE), write address width
- RD_ADDR_W, $clog2(SIZE), read address width

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- load_start  in  1  single-cycle pulse; begin accepting MEM_SIZE weights
- stream_start  in  1  single-cycle pulse; begin column read-out
- w_valid  in  1  host weight valid
- w_data  in  5  host weight value
- w_ready  out  1  controller accepts w_data
- wm_wr_en  out  1  memory write enable (registered)
- wm_wr_addr  out  WR_ADDR_W  memory write address (registered)
- wm_wr_data  out  5  memory write data (registered)
- wm_rd_en  out  1  memory read enable (registered)
- wm_rd_addr  out  RD_ADDR_W  memory read column (registered)
- weight_valid  out  1  memory weight output holds a new column this cycle
- weight_col  out  RD_ADDR_W  column index of the data qualified by weight_valid
- busy  out  1  state != IDLE
- loaded  out  1  a full weight set has been written since the last load_start or reset
- load_done  out  1  one-cycle pulse issued with the final write
- stream_done  out  1  one-cycle pulse issued with the final weight_valid
- err  out  1  one-cycle pulse; a start command was rejected

## Operation
- The FSM has four states: IDLE, LOAD, STREAM and DRAIN.
- **IDLE**
  - w_ready=0.
  - load_start moves to LOAD, clears loaded and sets the load counter to 0.
  - If loaded=1, stream_start moves to STREAM and sets the read counter to 0.
  - If loaded=0, stream_start is ignored and err pulses.
  - If load_start and stream_start arrive in the same cycle, load wins, stream_start is dropped and err pulses.
- **LOAD**
  - w_ready=1.
  - Each handshake (w_valid & w_ready) registers wm_wr_en=1, wm_wr_addr=count and wm_wr_data=w_data, then increments the count.
  - Address i maps linearly. Column r of lane k is written at address k*SIZE+r, so the host sends lane-major order.
  - On the handshake with count=MEM_SIZE-1, the FSM goes to IDLE.
  - The next cycle carries the final write together with load_done=1 and loaded=1.
  - Stalls (w_valid=0) hold the count; there is no timeout.
- **STREAM**
  - Each cycle registers wm_rd_en=1 and wm_rd_addr=count, then increments the count.
  - After the cycle with count=SIZE-1, the FSM goes to DRAIN.
  - wm_wr_en is always 0 in STREAM, because the memory gives write priority and would otherwise suppress the read.
- **DRAIN**
  - Lasts one cycle and covers the memory's one-cycle read latency.
  - Returns to IDLE.
- **Rejected commands:** any start pulse while busy=1 is ignored and err pulses the next cycle. Load and stream are never interrupted.
- **Reuse of weights:** loaded stays 1 across any number of streams. Memory contents are not touched by the controller outside LOAD.
- **weight_valid / weight_col:** these are wm_rd_en and wm_rd_addr delayed by one cycle, so they align with the memory's registered output.

## Timing
- **Reset:** asynchronous, active-low. All outputs are 0, state is IDLE and loaded=0.
  - A reset in mid-LOAD leaves a partial set in memory, but loaded=0, so a later stream is rejected.
  - A reset in mid-STREAM kills all pending weight_valid immediately.
- **Load timing** (load_start at cycle t):
  - w_ready=1 from t+1.
  - With back-to-back valid, handshakes occur at t+1..t+MEM_SIZE.
  - Writes appear at t+2..t+MEM_SIZE+1; load_done and loaded rise at t+MEM_SIZE+1.
- **Stream timing** (stream_start at cycle t):
  - wm_rd_en=1 at t+1..t+SIZE, with wm_rd_addr = 0..SIZE-1.
  - weight_valid=1 at t+2..t+SIZE+1, with weight_col = 0..SIZE-1.
  - stream_done pulses at t+SIZE+1 (DRAIN).
  - busy=0 at t+SIZE+2, and the earliest new start is accepted at t+SIZE+2.
- **err:** pulses exactly one cycle after the rejected start, once per rejected pulse.
- **Counter widths:**
  - The load counter is WR_ADDR_W bits; the terminal compare is on MEM_SIZE-1, with no reliance on wrap.
  - The read counter is RD_ADDR_W bits.

## Test plan
- **Reset values:** rst_n low -> every output 0. Release -> IDLE, w_ready=0.
- **Full load:** load_start, then 64 back-to-back weights with value i mod 32 -> wm_wr_addr runs 0..63 with matching data, load_done at t+65 and loaded=1. Insert random w_valid gaps -> identical write sequence, no extra writes.
- **Stream:** after load, stream_start at t -> wm_rd_addr 0..7 at t+1..t+8, weight_valid with weight_col 0..7 at t+2..t+9, stream_done at t+9, and wm_wr_en never 1. A second stream_start at t+10 -> identical sequence.
- **Rejection:**
  - stream_start before any load -> err at t+1, no reads.
  - load_start and stream_start in the same cycle -> load proceeds, err=1.
  - stream_start during LOAD -> err, load unaffected.
- **Reset mid-operation:** reset after 30 handshakes -> loaded=0 and wm_wr_en=0 immediately. Subsequent stream_start -> err.

Source files
------------

// File: rtl/weight_mem_ctrl_if.sv
// Host weight stream plus weight-memory port of the weight memory sequencer.
// master = host/DMA side, slave = the controller.
interface weight_mem_ctrl_if #(
    parameter int SIZE      = 8,
    parameter int WR_ADDR_W = $clog2(SIZE*SIZE),
    parameter int RD_ADDR_W = $clog2(SIZE)
);
    logic                 w_valid;
    logic [4:0]           w_data;
    logic                 w_ready;
    logic                 wm_wr_en;
    logic [WR_ADDR_W-1:0] wm_wr_addr;
    logic [4:0]           wm_wr_data;
    logic                 wm_rd_en;
    logic [RD_ADDR_W-1:0] wm_rd_addr;
    logic                 weight_valid;
    logic [RD_ADDR_W-1:0] weight_col;

    modport master (
        output w_valid, w_data,
        input  w_ready, wm_wr_en, wm_wr_addr, wm_wr_data,
        input  wm_rd_en, wm_rd_addr, weight_valid, weight_col
    );

    modport slave (
        input  w_valid, w_data,
        output w_ready, wm_wr_en, wm_wr_addr, wm_wr_data,
        output wm_rd_en, wm_rd_addr, weight_valid, weight_col
    );
endinterface

// File: rtl/weight_mem_ctrl.sv
// Weight memory sequencer: writes a SIZE*SIZE weight stream into memory and
// later replays it as SIZE column reads; writes and reads never overlap.
module weight_mem_ctrl #(
    parameter int SIZE      = 8,
    parameter int MEM_SIZE  = SIZE*SIZE,
    parameter int WR_ADDR_W = $clog2(MEM_SIZE),
    parameter int RD_ADDR_W = $clog2(SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              stream_start,
    weight_mem_ctrl_if.slave  bus,
    output logic              busy,
    output logic              loaded,
    output logic              load_done,
    output logic              stream_done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

    localparam logic [WR_ADDR_W-1:0] WR_LAST = WR_ADDR_W'(MEM_SIZE-1);
    localparam logic [RD_ADDR_W-1:0] RD_LAST = RD_ADDR_W'(SIZE-1);

    state_t               state;
    logic [WR_ADDR_W-1:0] wr_cnt;
    logic [RD_ADDR_W-1:0] rd_cnt;

    assign bus.w_ready = (state == LOAD);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            wr_cnt           <= '0;
            rd_cnt           <= '0;
            loaded           <= 1'b0;
            load_done        <= 1'b0;
            stream_done      <= 1'b0;
            err              <= 1'b0;
            bus.wm_wr_en     <= 1'b0;
            bus.wm_wr_addr   <= '0;
            bus.wm_wr_data   <= '0;
            bus.wm_rd_en     <= 1'b0;
            bus.wm_rd_addr   <= '0;
            bus.weight_valid <= 1'b0;
            bus.weight_col   <= '0;
        end else begin
            bus.wm_wr_en     <= 1'b0;
            bus.wm_rd_en     <= 1'b0;
            load_done        <= 1'b0;
            stream_done      <= 1'b0;
            err              <= 1'b0;
            // memory output is registered, so the qualifier trails the read by one cycle
            bus.weight_valid <= bus.wm_rd_en;
            bus.weight_col   <= bus.wm_rd_addr;

            case (state)
                IDLE: begin
                    if (load_start) begin
                        state  <= LOAD;
                        loaded <= 1'b0;
                        wr_cnt <= '0;
                        err    <= stream_start;
                    end else if (stream_start) begin
                        if (loaded) begin
                            // first read issues on the same edge so it lands at t+1
                            state          <= STREAM;
                            rd_cnt         <= '0;
                            bus.wm_rd_en   <= 1'b1;
                            bus.wm_rd_addr <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    err <= load_start | stream_start;
                    if (bus.w_valid && bus.w_ready) begin
                        bus.wm_wr_en   <= 1'b1;
                        bus.wm_wr_addr <= wr_cnt;
                        bus.wm_wr_data <= bus.w_data;
                        if (wr_cnt == WR_LAST) begin
                            state     <= IDLE;
                            load_done <= 1'b1;
                            loaded    <= 1'b1;
                        end else begin
                            wr_cnt <= wr_cnt + WR_ADDR_W'(1);
                        end
                    end
                end

                STREAM: begin
                    err <= load_start | stream_start;
                    if (rd_cnt == RD_LAST) begin
                        state       <= DRAIN;
                        stream_done <= 1'b1;
                    end else begin
                        rd_cnt         <= rd_cnt + RD_ADDR_W'(1);
                        bus.wm_rd_en   <= 1'b1;
                        bus.wm_rd_addr <= rd_cnt + RD_ADDR_W'(1);
                    end
                end

                DRAIN: begin
                    err   <= load_start | stream_start;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_weight_mem_ctrl.sv
// Directed/randomized bench for weight_mem_ctrl; a negedge monitor logs bus
// events with cycle stamps, and expected sequences are built from timing rules.
module tb_weight_mem_ctrl;
    localparam int SIZE = 8;
    localparam int MEM  = SIZE*SIZE;

    logic clk = 1'b0;
    logic rst_n, load_start, stream_start;
    logic busy, loaded, load_done, stream_done, err;

    always #5 clk = ~clk;

    weight_mem_ctrl_if bus();

    weight_mem_ctrl dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .stream_start(stream_start),
        .bus(bus.slave), .busy(busy), .loaded(loaded), .load_done(load_done),
        .stream_done(stream_done), .err(err)
    );

    typedef struct {int cyc; int a; int d;} ev_t;
    ev_t wr_q[$], rd_q[$], wv_q[$];
    int  hs_q[$], err_q[$], ld_q[$], sd_q[$];
    int  cyc = 0;
    int  collide = 0;
    int  checks = 0, failures = 0;
    int  wts[MEM];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.wm_wr_en)   wr_q.push_back(ev_t'{cyc, int'(bus.wm_wr_addr), int'(bus.wm_wr_data)});
            if (bus.wm_rd_en)   rd_q.push_back(ev_t'{cyc, int'(bus.wm_rd_addr), 0});
            if (bus.weight_valid) wv_q.push_back(ev_t'{cyc, int'(bus.weight_col), 0});
            if (bus.w_valid && bus.w_ready) hs_q.push_back(cyc);
            if (err)         err_q.push_back(cyc);
            if (load_done)   ld_q.push_back(cyc);
            if (stream_done) sd_q.push_back(cyc);
            if (bus.wm_wr_en && bus.wm_rd_en) collide <= collide + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Host side: offer wts[idx] with random gaps until n handshakes happen.
    task automatic send(input int n, input int gap, input int rej_at, output int t_rej);
        int idx = 0;
        int guard = 0;
        bit v, hs;
        t_rej = -1;
        while (idx < n && guard < 4000) begin
            v = ($urandom_range(0, 99) >= gap);
            bus.w_valid  = v;
            bus.w_data   = 5'(wts[idx]);
            stream_start = (guard == rej_at);
            if (guard == rej_at) t_rej = cyc;
            @(negedge clk);
            hs = v && (bus.w_ready === 1'b1);
            tick();
            stream_start = 1'b0;
            if (hs) idx++;
            guard++;
        end
        bus.w_valid = 1'b0;
        chk("send_count", idx, n);
    endtask

    task automatic do_load(input int gap, input int rej_at, input bit with_stream, input bit exact);
        int wb = wr_q.size();
        int hb = hs_q.size();
        int lb = ld_q.size();
        int eb = err_q.size();
        int exp_err[$];
        int t0, t_rej;
        t0 = cyc;
        load_start   = 1'b1;
        stream_start = with_stream;
        tick();
        load_start   = 1'b0;
        stream_start = 1'b0;
        chk("w_ready_t1", bus.w_ready, 1);
        chk("loaded_cleared", loaded, 0);
        if (with_stream) exp_err.push_back(t0 + 1);
        send(MEM, gap, rej_at, t_rej);
        if (t_rej >= 0) exp_err.push_back(t_rej + 1);
        repeat (3) tick();
        chk("load_nwr", wr_q.size() - wb, MEM);
        chk("load_nhs", hs_q.size() - hb, MEM);
        for (int i = 0; i < MEM; i++) begin
            if (wr_q.size() > wb + i && hs_q.size() > hb + i) begin
                chk("wr_addr", wr_q[wb+i].a, i);
                chk("wr_data", wr_q[wb+i].d, wts[i] % 32);
                chk("wr_cyc", wr_q[wb+i].cyc, hs_q[hb+i] + 1);
                if (exact) chk("hs_cyc", hs_q[hb+i], t0 + 1 + i);
            end
        end
        chk("load_done_n", ld_q.size() - lb, 1);
        if (ld_q.size() > lb && hs_q.size() >= hb + MEM) begin
            chk("load_done_cyc", ld_q[lb], hs_q[hb+MEM-1] + 1);
            if (exact) chk("load_done_t65", ld_q[lb], t0 + MEM + 1);
        end
        chk("loaded_set", loaded, 1);
        chk("busy_after_load", busy, 0);
        chk("load_err_n", err_q.size() - eb, exp_err.size());
        foreach (exp_err[k])
            if (err_q.size() > eb + k) chk("load_err_cyc", err_q[eb+k], exp_err[k]);
    endtask

    // Leaves the process in period t+SIZE+2 so a back-to-back start can follow.
    task automatic do_stream();
        int rb = rd_q.size();
        int vb = wv_q.size();
        int sb = sd_q.size();
        int wb = wr_q.size();
        int eb = err_q.size();
        int t0 = cyc;
        stream_start = 1'b1;
        tick();
        stream_start = 1'b0;
        repeat (SIZE + 1) tick();
        chk("stream_busy_end", busy, 0);
        chk("stream_nrd", rd_q.size() - rb, SIZE);
        chk("stream_nwv", wv_q.size() - vb, SIZE);
        for (int i = 0; i < SIZE; i++) begin
            if (rd_q.size() > rb + i) begin
                chk("rd_addr", rd_q[rb+i].a, i);
                chk("rd_cyc", rd_q[rb+i].cyc, t0 + 1 + i);
            end
            if (wv_q.size() > vb + i) begin
                chk("wv_col", wv_q[vb+i].a, i);
                chk("wv_cyc", wv_q[vb+i].cyc, t0 + 2 + i);
            end
        end
        chk("stream_done_n", sd_q.size() - sb, 1);
        if (sd_q.size() > sb) chk("stream_done_cyc", sd_q[sb], t0 + SIZE + 1);
        chk("stream_no_wr", wr_q.size() - wb, 0);
        chk("stream_no_err", err_q.size() - eb, 0);
        chk("stream_loaded_kept", loaded, 1);
    endtask

    task automatic reject_stream(input string tag);
        int eb = err_q.size();
        int rb = rd_q.size();
        int t0 = cyc;
        stream_start = 1'b1;
        tick();
        stream_start = 1'b0;
        repeat (SIZE + 3) tick();
        chk({tag, "_err_n"}, err_q.size() - eb, 1);
        if (err_q.size() > eb) chk({tag, "_err_cyc"}, err_q[eb], t0 + 1);
        chk({tag, "_no_rd"}, rd_q.size() - rb, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int dummy;
        rst_n = 1'b0; load_start = 1'b0; stream_start = 1'b0;
        bus.w_valid = 1'b0; bus.w_data = '0;
        repeat (3) tick();
        chk("reset_outputs",
            {bus.wm_wr_en, bus.wm_wr_addr, bus.wm_wr_data, bus.wm_rd_en, bus.wm_rd_addr,
             bus.weight_valid, bus.weight_col, bus.w_ready, busy, loaded, load_done,
             stream_done, err}, 0);
        rst_n = 1'b1;
        tick();
        chk("release_busy", busy, 0);
        chk("release_w_ready", bus.w_ready, 0);

        reject_stream("unloaded");

        for (int i = 0; i < MEM; i++) wts[i] = i % 32;
        do_load(0, -1, 1'b0, 1'b1);
        do_stream();
        do_stream();

        for (int i = 0; i < MEM; i++) wts[i] = int'($urandom_range(0, 31));
        do_load(40, 10, 1'b0, 1'b0);
        do_stream();

        for (int i = 0; i < MEM; i++) wts[i] = int'($urandom_range(0, 31));
        do_load(25, -1, 1'b1, 1'b0);

        // reset while a stream is in flight
        stream_start = 1'b1;
        tick();
        stream_start = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_stream_wv", bus.weight_valid, 0);
        chk("rst_stream_rd", bus.wm_rd_en, 0);
        chk("rst_stream_busy", busy, 0);
        chk("rst_stream_loaded", loaded, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // reset after 30 handshakes of a load
        for (int i = 0; i < MEM; i++) wts[i] = int'($urandom_range(0, 31));
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        send(30, 0, -1, dummy);
        chk("mid_load_wr_live", bus.wm_wr_en, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_load_loaded", loaded, 0);
        chk("rst_load_wr_en", bus.wm_wr_en, 0);
        chk("rst_load_w_ready", bus.w_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();
        reject_stream("after_rst");

        chk("no_rd_wr_same_cycle", collide, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
